// File: rtl/keypad_sender_pkg.sv
// Shared definitions for the keypad sender: state encodings, key bus width,
// BCD-to-one-hot key mapping and the BCD legality check.
package keypad_sender_pkg;

    localparam int KEY_W = 10;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        PRESS = 2'd1,
        GAP   = 2'd2
    } ks_state_t;

    // Exact inverse of the lock's key encoder; non-BCD nibbles map to no key.
    function automatic logic [KEY_W-1:0] key_onehot(input logic [3:0] d);
        logic [KEY_W-1:0] k;
        k = '0;
        case (d)
            4'd0: k = 10'b00_0000_0001;
            4'd1: k = 10'b00_0000_0010;
            4'd2: k = 10'b00_0000_0100;
            4'd3: k = 10'b00_0000_1000;
            4'd4: k = 10'b00_0001_0000;
            4'd5: k = 10'b00_0010_0000;
            4'd6: k = 10'b00_0100_0000;
            4'd7: k = 10'b00_1000_0000;
            4'd8: k = 10'b01_0000_0000;
            4'd9: k = 10'b10_0000_0000;
            default: k = '0;
        endcase
        return k;
    endfunction

    function automatic logic bcd_legal(input logic [15:0] c);
        return (c[15:12] <= 4'd9) && (c[11:8] <= 4'd9) &&
               (c[7:4]   <= 4'd9) && (c[3:0]  <= 4'd9);
    endfunction

    // Digit 0 is the most significant nibble (sent first).
    function automatic logic [3:0] digit_sel(input logic [15:0] c, input logic [1:0] i);
        logic [3:0] d;
        case (i)
            2'd0:    d = c[15:12];
            2'd1:    d = c[11:8];
            2'd2:    d = c[7:4];
            default: d = c[3:0];
        endcase
        return d;
    endfunction

endpackage

// File: rtl/keysend_timer.sv
// 8-bit loadable down-counter with zero flag, shared by the press and gap phases.
module keysend_timer (
    input  logic       ck,
    input  logic       reset,
    input  logic       load,
    input  logic [7:0] load_val,
    input  logic       dec,
    output logic       zero
);

    logic [7:0] count;

    always_ff @(posedge ck) begin
        if (reset) begin
            count <= 8'd0;
        end else if (load) begin
            count <= load_val;
        end else if (dec && (count != 8'd0)) begin
            count <= count - 8'd1;
        end
    end

    assign zero = (count == 8'd0);

endmodule

// File: rtl/keypad_sender.sv
// Plays a latched 4-digit BCD code onto a one-hot ten-key bus as timed
// press/release pairs, with start/busy/done handshake and abort.
module keypad_sender
    import keypad_sender_pkg::*;
#(
    parameter int PRESS_CYC = 4,
    parameter int GAP_CYC   = 4
) (
    input  logic             ck,
    input  logic             reset,
    input  logic             start,
    input  logic             abort,
    input  logic [15:0]      code,
    output logic [KEY_W-1:0] tenkey,
    output logic             busy,
    output logic             done,
    output logic             err
);

    localparam logic [7:0] PRESS_RL = 8'(PRESS_CYC - 1);
    localparam logic [7:0] GAP_RL   = 8'(GAP_CYC - 1);

    ks_state_t        state, state_n;
    logic [1:0]       idx, idx_n;
    logic [15:0]      code_q, code_n;
    logic [KEY_W-1:0] tenkey_n;
    logic             busy_n, done_n, err_n;
    logic             t_load, t_dec, t_zero;
    logic [7:0]       t_val;

    keysend_timer u_timer (
        .ck       (ck),
        .reset    (reset),
        .load     (t_load),
        .load_val (t_val),
        .dec      (t_dec),
        .zero     (t_zero)
    );

    always_ff @(posedge ck) begin
        if (reset) begin
            state  <= IDLE;
            idx    <= 2'd0;
            code_q <= 16'd0;
            tenkey <= '0;
            busy   <= 1'b0;
            done   <= 1'b0;
            err    <= 1'b0;
        end else begin
            state  <= state_n;
            idx    <= idx_n;
            code_q <= code_n;
            tenkey <= tenkey_n;
            busy   <= busy_n;
            done   <= done_n;
            err    <= err_n;
        end
    end

    always_comb begin
        state_n  = state;
        idx_n    = idx;
        code_n   = code_q;
        tenkey_n = tenkey;
        busy_n   = busy;
        done_n   = 1'b0;
        err_n    = 1'b0;
        t_load   = 1'b0;
        t_dec    = 1'b0;
        t_val    = PRESS_RL;

        // Abort overrides everything, including a simultaneous start.
        if (abort) begin
            state_n  = IDLE;
            idx_n    = 2'd0;
            tenkey_n = '0;
            busy_n   = 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    tenkey_n = '0;
                    busy_n   = 1'b0;
                    if (start) begin
                        if (bcd_legal(code)) begin
                            code_n   = code;
                            idx_n    = 2'd0;
                            state_n  = PRESS;
                            busy_n   = 1'b1;
                            tenkey_n = key_onehot(code[15:12]);
                            t_load   = 1'b1;
                            t_val    = PRESS_RL;
                        end else begin
                            err_n = 1'b1;
                        end
                    end
                end
                PRESS: begin
                    if (t_zero) begin
                        state_n  = GAP;
                        tenkey_n = '0;
                        t_load   = 1'b1;
                        t_val    = GAP_RL;
                    end else begin
                        t_dec = 1'b1;
                    end
                end
                GAP: begin
                    tenkey_n = '0;
                    if (t_zero) begin
                        if (idx != 2'd3) begin
                            idx_n    = idx + 2'd1;
                            state_n  = PRESS;
                            tenkey_n = key_onehot(digit_sel(code_q, idx + 2'd1));
                            t_load   = 1'b1;
                            t_val    = PRESS_RL;
                        end else begin
                            state_n = IDLE;
                            busy_n  = 1'b0;
                            done_n  = 1'b1;
                        end
                    end else begin
                        t_dec = 1'b1;
                    end
                end
                default: begin
                    state_n  = IDLE;
                    tenkey_n = '0;
                    busy_n   = 1'b0;
                end
            endcase
        end
    end

endmodule
